// File: rtl/clk_mon_pkg.sv
// Shared types and helpers for the divider-tap monitor.
package clk_mon_pkg;

    localparam int SEL_W = 6;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        STALLED = 2'd2
    } mon_state_t;

    // Nominal period of tap 'sel' in CLK_in cycles.
    function automatic logic [63:0] exp_period(input logic [SEL_W-1:0] sel);
        exp_period = 64'd1 << sel;
    endfunction

endpackage

// File: rtl/tap_sync.sv
// Selects one divider tap, brings it into the CLK_in domain and reports
// clean rising edges.
// Edges are suppressed while the synchronizer still holds samples from the
// previously selected tap.
module tap_sync
    import clk_mon_pkg::*;
#(
    parameter int SIZE        = 36,
    parameter int SYNC_STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [SIZE:0]    i_taps,
    input  logic [SEL_W-1:0] i_sel,
    input  logic             i_selChange,
    output logic             o_rise
);

    localparam int                 BLANK_W    = $clog2(SYNC_STAGES + 2);
    localparam logic [BLANK_W-1:0] BLANK_LOAD = BLANK_W'(SYNC_STAGES + 1);
    localparam logic [SEL_W-1:0]   SIZE_SEL   = SEL_W'(SIZE);

    logic                   w_tap;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;
    logic [BLANK_W-1:0]     r_blankCnt;

    // Tap mux. Tap 0 is CLK_in itself and out-of-range indices have no tap,
    // so both feed a constant low instead of an unsampleable or undefined bit.
    always_comb begin
        w_tap = 1'b0;
        if ((i_sel != '0) && (i_sel <= SIZE_SEL)) begin
            w_tap = i_taps[i_sel];
        end
    end

    // Synchronizer chain followed by the history flop used for edge detection.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= '0;
            r_hist <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], w_tap};
            r_hist <= r_sync[SYNC_STAGES-1];
        end
    end

    // Blanking window: long enough for old-tap samples to drain out of the
    // chain and the history flop.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_blankCnt <= '0;
        end else if (i_selChange) begin
            r_blankCnt <= BLANK_LOAD;
        end else if (r_blankCnt != '0) begin
            r_blankCnt <= r_blankCnt - BLANK_W'(1);
        end
    end

    assign o_rise = r_sync[SYNC_STAGES-1] & ~r_hist & (r_blankCnt == '0) & ~i_selChange;

endmodule

// File: rtl/clk_tap_monitor.sv
// Consumer end of the divider bus: turns the selected tap into Tick enables,
// measures its period and flags stalls or a wrong frequency.
module clk_tap_monitor
    import clk_mon_pkg::*;
#(
    parameter int SIZE        = 36,
    parameter int CNT_W       = 38,
    parameter int SYNC_STAGES = 2
) (
    input  logic             CLK_in,
    input  logic             Reset,
    input  logic [SIZE:0]    CLKS_in,
    input  logic [SEL_W-1:0] Sel,
    output logic             Tick,
    output logic [CNT_W-1:0] Period,
    output logic             Period_Valid,
    output logic             Stalled,
    output logic             Freq_Err,
    output logic             Sel_Err
);

    localparam logic [SEL_W-1:0] SIZE_SEL = SEL_W'(SIZE);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [SEL_W-1:0] r_selQ;
    logic             r_selErr;
    logic             w_selBad;
    logic             w_selChange;
    logic             w_rise;

    mon_state_t       r_state;
    mon_state_t       w_stateNext;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cntNext;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] w_periodNext;
    logic             r_periodValid;
    logic             w_periodValidNext;
    logic             r_stalled;
    logic             w_stalledNext;
    logic             r_freqErr;
    logic             w_freqErrNext;
    logic             r_tick;
    logic             w_tickNext;

    logic [CNT_W-1:0] w_expPeriod;
    logic [CNT_W-1:0] w_timeoutVal;
    logic             w_timeout;

    assign w_selBad     = (Sel == '0) || (Sel > SIZE_SEL);
    assign w_selChange  = (Sel != r_selQ);
    assign w_expPeriod  = CNT_W'(exp_period(r_selQ));
    assign w_timeoutVal = CNT_W'(exp_period(r_selQ) << 1);
    assign w_timeout    = (r_cnt == w_timeoutVal);

    // Registered copy of the select and its range check.
    always_ff @(posedge CLK_in or posedge Reset) begin
        if (Reset) begin
            r_selQ   <= '0;
            r_selErr <= 1'b0;
        end else begin
            r_selQ   <= Sel;
            r_selErr <= w_selBad;
        end
    end

    tap_sync #(
        .SIZE        (SIZE),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_tapSync (
        .i_clk       (CLK_in),
        .i_rst       (Reset),
        .i_taps      (CLKS_in),
        .i_sel       (r_selQ),
        .i_selChange (w_selChange),
        .o_rise      (w_rise)
    );

    // Next-state logic. Select change beats the select-error hold, which
    // beats normal operation; a rise always beats a timeout.
    always_comb begin
        w_stateNext       = r_state;
        w_cntNext         = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_ONE;
        w_periodNext      = r_period;
        w_periodValidNext = 1'b0;
        w_stalledNext     = r_stalled;
        w_freqErrNext     = r_freqErr;
        w_tickNext        = 1'b0;

        if (w_selChange) begin
            w_stateNext   = IDLE;
            w_cntNext     = CNT_ONE;
            w_periodNext  = '0;
            w_stalledNext = 1'b0;
            w_freqErrNext = 1'b0;
        end else if (r_selErr) begin
            w_stateNext   = IDLE;
            w_cntNext     = CNT_ONE;
            w_stalledNext = 1'b0;
            w_freqErrNext = 1'b0;
        end else begin
            w_tickNext = w_rise;
            case (r_state)
                IDLE: begin
                    if (w_rise) begin
                        w_stateNext = MEASURE;
                        w_cntNext   = CNT_ONE;
                    end else if (w_timeout) begin
                        w_stateNext   = STALLED;
                        w_stalledNext = 1'b1;
                    end
                end
                MEASURE: begin
                    if (w_rise) begin
                        w_periodNext      = r_cnt;
                        w_periodValidNext = 1'b1;
                        w_freqErrNext     = (r_cnt != w_expPeriod);
                        w_cntNext         = CNT_ONE;
                    end else if (w_timeout) begin
                        w_stateNext   = STALLED;
                        w_stalledNext = 1'b1;
                    end
                end
                STALLED: begin
                    if (w_rise) begin
                        w_stateNext   = MEASURE;
                        w_stalledNext = 1'b0;
                        w_cntNext     = CNT_ONE;
                    end
                end
                default: begin
                    w_stateNext = IDLE;
                    w_cntNext   = CNT_ONE;
                end
            endcase
        end
    end

    // State, period counter and output registers.
    always_ff @(posedge CLK_in or posedge Reset) begin
        if (Reset) begin
            r_state       <= IDLE;
            r_cnt         <= CNT_ONE;
            r_period      <= '0;
            r_periodValid <= 1'b0;
            r_stalled     <= 1'b0;
            r_freqErr     <= 1'b0;
            r_tick        <= 1'b0;
        end else begin
            r_state       <= w_stateNext;
            r_cnt         <= w_cntNext;
            r_period      <= w_periodNext;
            r_periodValid <= w_periodValidNext;
            r_stalled     <= w_stalledNext;
            r_freqErr     <= w_freqErrNext;
            r_tick        <= w_tickNext;
        end
    end

    assign Tick         = r_tick;
    assign Period       = r_period;
    assign Period_Valid = r_periodValid;
    assign Stalled      = r_stalled;
    assign Freq_Err     = r_freqErr;
    assign Sel_Err      = r_selErr;

endmodule

// File: tb/tb_clk_tap_monitor.sv
// Bench for clk_tap_monitor: divider model on the tap bus, table of select
// settings, period scoreboard, and directed stall / wrong-frequency / reset
// sequences.
module tb_clk_tap_monitor;

    localparam int SIZE        = 36;
    localparam int CNT_W       = 38;
    localparam int SYNC_STAGES = 2;

    typedef struct {
        logic [CNT_W-1:0] period;
        logic             freqErr;
    } exp_t;

    typedef struct {
        logic [5:0]       sel;
        logic             selErr;
        logic [CNT_W-1:0] expPeriod;
    } vec_t;

    logic             clk = 1'b0;
    logic             reset;
    logic [SIZE:0]    clks;
    logic [5:0]       sel;
    logic             tick;
    logic [CNT_W-1:0] period;
    logic             pv;
    logic             stalled;
    logic             freqErr;
    logic             selErr;

    logic [39:0] divCnt;
    int          c10;
    int          tap3Mode;
    logic        tap3Level;
    logic        force5Low;

    exp_t sbQ[$];
    logic sbStrict;
    int   testsRun;
    int   failCount;
    vec_t vecs[8];

    clk_tap_monitor #(
        .SIZE        (SIZE),
        .CNT_W       (CNT_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .CLK_in       (clk),
        .Reset        (reset),
        .CLKS_in      (clks),
        .Sel          (sel),
        .Tick         (tick),
        .Period       (period),
        .Period_Valid (pv),
        .Stalled      (stalled),
        .Freq_Err     (freqErr),
        .Sel_Err      (selErr)
    );

    always #5 clk = ~clk;

    // Divider model: bit i has period 2^i; tap 3 can be swapped for a
    // period-10 wave or a manual level, tap 5 can be forced low.
    always_comb begin
        clks = {divCnt[SIZE-1:0], clk};
        if (tap3Mode == 1) clks[3] = (c10 < 5);
        else if (tap3Mode == 2) clks[3] = tap3Level;
        if (force5Low) clks[5] = 1'b0;
    end

    initial begin
        divCnt = '0;
        c10    = 0;
        forever begin
            @(negedge clk);
            divCnt = divCnt + 40'd1;
            c10    = (c10 == 9) ? 0 : c10 + 1;
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic failNow(input string name);
        testsRun++;
        failCount++;
        $display("[TB] FAIL %s: got no event within budget, expected one", name);
    endtask

    // Scoreboard consumer: every Period_Valid pops one expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (pv === 1'b1) begin
                if (sbQ.size() > 0) begin
                    e = sbQ.pop_front();
                    checkOutput("period", period, e.period);
                    checkOutput("freqErr", freqErr, e.freqErr);
                    checkOutput("stalledAtPv", stalled, 0);
                end else if (sbStrict) begin
                    checkOutput("unexpectedPeriodValid", pv, 0);
                end
            end
        end
    end

    task automatic waitTick(input int budget, input string name, output bit found);
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (tick === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) failNow(name);
    endtask

    task automatic expectPeriod(input logic [CNT_W-1:0] p, input logic fe, input string name);
        exp_t e;
        bit   done;
        @(negedge clk);
        e.period  = p;
        e.freqErr = fe;
        sbQ.push_back(e);
        done = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (sbQ.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            failNow(name);
            sbQ.delete();
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        int nt;
        int bad;
        int gap;
        int ticks;
        int window;
        bit found;
        @(negedge clk);
        sel = v.sel;
        @(negedge clk);
        sbStrict = 1'b1;
        checkOutput($sformatf("sel%0d selErr", v.sel), selErr, v.selErr);
        checkOutput($sformatf("sel%0d periodCleared", v.sel), period, 0);
        if (v.selErr) begin
            bad = 0;
            repeat (40) begin
                if (tick || pv || stalled || freqErr || (period != 0) || !selErr) bad++;
                @(negedge clk);
            end
            checkOutput($sformatf("sel%0d selErrHold", v.sel), bad, 0);
        end else begin
            nt = 0;
            repeat (SYNC_STAGES + 1) begin
                @(negedge clk);
                nt += int'(tick);
            end
            checkOutput($sformatf("sel%0d blankTick", v.sel), nt, 0);
            waitTick(4 * (1 << v.sel) + 16, $sformatf("sel%0d firstTick", v.sel), found);
            if (found) expectPeriod(v.expPeriod, 1'b0, $sformatf("sel%0d periodValid", v.sel));
            sbStrict = 1'b0;
            window = (5 * (1 << v.sel) > 100) ? 5 * (1 << v.sel) : 100;
            gap   = 0;
            ticks = 0;
            repeat (window) begin
                @(negedge clk);
                gap++;
                if (tick) begin
                    if (ticks > 0) checkOutput($sformatf("sel%0d tickSpacing", v.sel), gap, v.expPeriod);
                    ticks++;
                    gap = 0;
                end
            end
            checkOutput($sformatf("sel%0d tickCount", v.sel), (ticks >= 3), 1);
        end
        sbStrict = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit found;
        int lat[4];
        int n;
        testsRun  = 0;
        failCount = 0;
        sbStrict  = 1'b0;
        tap3Mode  = 0;
        tap3Level = 1'b0;
        force5Low = 1'b0;
        sel       = 6'd0;
        reset     = 1'b1;

        vecs[0] = '{6'd3,  1'b0, 38'd8};
        vecs[1] = '{6'd1,  1'b0, 38'd2};
        vecs[2] = '{6'd4,  1'b0, 38'd16};
        vecs[3] = '{6'd2,  1'b0, 38'd4};
        vecs[4] = '{6'd0,  1'b1, 38'd0};
        vecs[5] = '{6'd40, 1'b1, 38'd0};
        vecs[6] = '{6'd2,  1'b0, 38'd4};
        vecs[7] = '{6'd5,  1'b0, 38'd32};

        repeat (3) @(negedge clk);
        checkOutput("rstTick", tick, 0);
        checkOutput("rstPeriod", period, 0);
        checkOutput("rstPv", pv, 0);
        checkOutput("rstStalled", stalled, 0);
        checkOutput("rstFreqErr", freqErr, 0);
        checkOutput("rstSelErr", selErr, 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);

        // Stall on tap 5: Stalled exactly 64 cycles after the last accepted rise.
        waitTick(100, "stallLastTick", found);
        force5Low = 1'b1;
        n = 0;
        for (int j = 1; j <= 63; j++) begin
            @(negedge clk);
            sbStrict = 1'b1;
            if (stalled || tick) n++;
        end
        checkOutput("stallEarly", n, 0);
        @(negedge clk);
        checkOutput("stallAt64", stalled, 1);
        repeat (10) @(negedge clk);
        checkOutput("stallHeld", stalled, 1);
        for (int i = 0; i < 40; i++) begin
            if (divCnt[4] == 1'b0) break;
            @(negedge clk);
        end
        force5Low = 1'b0;
        waitTick(80, "stallReleaseTick", found);
        checkOutput("stallClearOnTick", stalled, 0);
        checkOutput("noPvOnStallExit", pv, 0);
        expectPeriod(38'd32, 1'b0, "stallRecoverPeriod");
        sbStrict = 1'b0;

        // Wrong frequency on tap 3, then back to the divider.
        tap3Mode = 1;
        @(negedge clk);
        sel = 6'd3;
        waitTick(60, "p10FirstTick", found);
        expectPeriod(38'd10, 1'b1, "p10Period1");
        expectPeriod(38'd10, 1'b1, "p10Period2");
        tap3Mode = 0;
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (pv) n++;
            if (n == 2) break;
        end
        checkOutput("p8SkipPv", n, 2);
        expectPeriod(38'd8, 1'b0, "p8Period");

        // Tick latency from the first edge that samples the tap high.
        tap3Mode  = 2;
        tap3Level = 1'b0;
        repeat (10) @(negedge clk);
        tap3Level = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            lat[i] = int'(tick);
        end
        checkOutput("latency1", lat[0], 0);
        checkOutput("latency2", lat[1], 0);
        checkOutput("latency3", lat[2], 1);
        checkOutput("latency4", lat[3], 0);
        tap3Mode = 0;

        // Reset in the middle of a tap-6 measurement.
        @(negedge clk);
        sel = 6'd6;
        waitTick(150, "sel6FirstTick", found);
        expectPeriod(38'd64, 1'b0, "sel6Period");
        waitTick(100, "sel6Tick", found);
        repeat (20) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        sbStrict = 1'b1;
        checkOutput("midRstTick", tick, 0);
        checkOutput("midRstPeriod", period, 0);
        checkOutput("midRstPv", pv, 0);
        checkOutput("midRstStalled", stalled, 0);
        checkOutput("midRstFreqErr", freqErr, 0);
        checkOutput("midRstSelErr", selErr, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        waitTick(160, "postRstTick", found);
        checkOutput("postRstNoPv", pv, 0);
        checkOutput("postRstPeriod0", period, 0);
        expectPeriod(38'd64, 1'b0, "postRstPeriod");
        sbStrict = 1'b0;

        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
